// File: rtl/debounce_pkg.sv
// Shared types and default timing for the input debouncer.
// Enumerators keep the upper-case names used throughout the debounce design docs.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_CHK_HIGH = 2'd1,
    ST_HIGH     = 2'd2,
    ST_CHK_LOW  = 2'd3
  } t_debounce_state;

  localparam int unsigned c_NUM_CH_DEFAULT = 4;
  localparam int unsigned c_T_BITS_DEFAULT = 21;
  localparam int unsigned c_T_VAL_DEFAULT  = 1000000;  // 10 ms at 100 MHz

endpackage

// File: rtl/switch_debounce_ch.sv
// Single debounce channel: 2-flop synchroniser, saturating timer, timed Moore FSM
// and registered one-cycle rise/fall pulses.
module switch_debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned par_T_debounce_bits = c_T_BITS_DEFAULT,
  parameter int unsigned par_T_debounce_val  = c_T_VAL_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sw,
  output logic o_sw_deb,
  output logic o_sw_rise,
  output logic o_sw_fall
);

  localparam logic [par_T_debounce_bits-1:0] c_T_MAX =
    par_T_debounce_bits'(par_T_debounce_val - 1);

  logic                           r_sync1;
  logic                           r_sync2;
  logic [par_T_debounce_bits-1:0] r_timer;
  t_debounce_state                r_state;
  t_debounce_state                w_next;
  logic                           r_rise;
  logic                           r_fall;

  // Input test is checked before the timer so a late glitch always wins.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LOW:      if (r_sync2) w_next = ST_CHK_HIGH;
      ST_CHK_HIGH: begin
        if (!r_sync2)               w_next = ST_LOW;
        else if (r_timer >= c_T_MAX) w_next = ST_HIGH;
      end
      ST_HIGH:     if (!r_sync2) w_next = ST_CHK_LOW;
      ST_CHK_LOW:  begin
        if (r_sync2)                w_next = ST_HIGH;
        else if (r_timer >= c_T_MAX) w_next = ST_LOW;
      end
      default:     w_next = ST_LOW;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_timer <= '0;
      r_state <= ST_LOW;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
      r_state <= w_next;
      if (w_next != r_state) begin
        r_timer <= '0;
      end else if (r_timer < c_T_MAX) begin
        r_timer <= r_timer + par_T_debounce_bits'(1);
      end
      r_rise <= (r_state == ST_CHK_HIGH) && (w_next == ST_HIGH);
      r_fall <= (r_state == ST_CHK_LOW) && (w_next == ST_LOW);
    end
  end

  assign o_sw_deb  = (r_state == ST_HIGH) || (r_state == ST_CHK_LOW);
  assign o_sw_rise = r_rise;
  assign o_sw_fall = r_fall;

endmodule

// File: rtl/multi_input_debounce.sv
// Array of independent debounce channels for board buttons and switches.
module multi_input_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned par_NUM_CH          = c_NUM_CH_DEFAULT,
  parameter int unsigned par_T_debounce_bits = c_T_BITS_DEFAULT,
  parameter int unsigned par_T_debounce_val  = c_T_VAL_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [par_NUM_CH-1:0] i_sw,
  output logic [par_NUM_CH-1:0] o_sw_deb,
  output logic [par_NUM_CH-1:0] o_sw_rise,
  output logic [par_NUM_CH-1:0] o_sw_fall
);

  for (genvar g = 0; g < par_NUM_CH; g++) begin : g_ch
    switch_debounce_ch #(
      .par_T_debounce_bits(par_T_debounce_bits),
      .par_T_debounce_val (par_T_debounce_val)
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_sw     (i_sw[g]),
      .o_sw_deb (o_sw_deb[g]),
      .o_sw_rise(o_sw_rise[g]),
      .o_sw_fall(o_sw_fall[g])
    );
  end

endmodule
